// File: rtl/text_lcd_ctrl.sv
// text_lcd_ctrl
// -----------------------------------------------------------------------------
// HD44780-style character LCD controller with a writable ROWS x COLS character
// buffer. After reset it runs the power-on command sequence once, then
// refreshes the panel from the buffer in an endless loop of frames.
//
// Every command or character occupies one "slot" of N cycles. RS and DB are
// loaded on slot cycle 0 and held for the whole slot. E is high on slot cycles
// 1..EN_W. All pin outputs come straight from flops.
//
// Ports
//   clk         system clock
//   rst         asynchronous active-high reset
//   wr_en       buffer write strobe (sampled every cycle)
//   wr_addr     linear character index row*COLS+col; out-of-range is dropped
//   wr_data     character code to store
//   clr         one-cycle pulse: every buffer entry becomes 0x20 (beats wr_en)
//   ready       high once the init sequence has completed
//   frame_done  one-cycle pulse at the end of each full refresh frame
//   lcd_enb     LCD E pin
//   lcd_rs      LCD RS (0 = command, 1 = data)
//   lcd_rw      LCD RW, always 0 (write only)
//   lcd_data    LCD DB7..DB0
// -----------------------------------------------------------------------------
module text_lcd_ctrl #(
    parameter int COLS        = 16,
    parameter int ROWS        = 2,
    parameter int INIT_WAIT   = 70,
    parameter int CMD_HOLD    = 30,
    parameter int CLEAR_WAIT  = 200,
    parameter int CHAR_HOLD   = 20,
    parameter int REFRESH_GAP = 400,
    parameter int EN_W        = 4,
    localparam int ADDR_W     = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              clr,
    output logic              ready,
    output logic              frame_done,
    output logic              lcd_enb,
    output logic              lcd_rs,
    output logic              lcd_rw,
    output logic [7:0]        lcd_data
);

    localparam int DEPTH   = ROWS * COLS;
    localparam int MAX_A   = (INIT_WAIT > CMD_HOLD) ? INIT_WAIT : CMD_HOLD;
    localparam int MAX_B   = (CLEAR_WAIT > CHAR_HOLD) ? CLEAR_WAIT : CHAR_HOLD;
    localparam int MAX_C   = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_MAX = (MAX_C > REFRESH_GAP) ? MAX_C : REFRESH_GAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1;

    // Function set: 8-bit bus, 5x8 font, two-line mode whenever more than one row.
    localparam logic [7:0] FUNC_CMD = (ROWS > 1) ? 8'h38 : 8'h30;

    typedef enum logic [2:0] {
        S_WAIT  = 3'd0,
        S_FUNC  = 3'd1,
        S_DISP  = 3'd2,
        S_ENTRY = 3'd3,
        S_CLEAR = 3'd4,
        S_ADDR  = 3'd5,
        S_CHAR  = 3'd6,
        S_GAP   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic               ready_q, ready_d;
    logic               frame_done_q, frame_done_d;
    logic               enb_q, enb_d;
    logic               rs_q, rs_d;
    logic [7:0]         data_q, data_d;
    logic [7:0]         buf_q [DEPTH];
    logic [7:0]         buf_d [DEPTH];
    logic [ADDR_W-1:0]  rd_idx_s;
    logic [7:0]         slot_data_s;

    // Last counter value of the slot belonging to a state.
    function automatic logic [CNT_W-1:0] slot_last(input state_t s);
        case (s)
            S_WAIT:                 slot_last = CNT_W'(INIT_WAIT - 1);
            S_FUNC, S_DISP, S_ENTRY: slot_last = CNT_W'(CMD_HOLD - 1);
            S_CLEAR:                slot_last = CNT_W'(CLEAR_WAIT - 1);
            S_ADDR, S_CHAR:         slot_last = CNT_W'(CHAR_HOLD - 1);
            S_GAP:                  slot_last = CNT_W'(REFRESH_GAP - 1);
            default:                slot_last = '0;
        endcase
    endfunction

    // DDRAM start address of a display row (rows 2/3 continue lines 0/1).
    function automatic logic [7:0] row_base(input logic [ROW_W-1:0] r);
        case (int'(r))
            0:       row_base = 8'h00;
            1:       row_base = 8'h40;
            2:       row_base = 8'(COLS);
            3:       row_base = 8'(64 + COLS);
            default: row_base = 8'h00;
        endcase
    endfunction

    // Sequencer: slot counter, state, and refresh row/column position.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        row_d   = row_q;
        col_d   = col_q;
        if (cnt_q == slot_last(state_q)) begin
            cnt_d = '0;
            case (state_q)
                S_WAIT:  state_d = S_FUNC;
                S_FUNC:  state_d = S_DISP;
                S_DISP:  state_d = S_ENTRY;
                S_ENTRY: state_d = S_CLEAR;
                S_CLEAR: begin
                    state_d = S_ADDR;
                    row_d   = '0;
                end
                S_ADDR: begin
                    state_d = S_CHAR;
                    col_d   = '0;
                end
                S_CHAR: begin
                    if (int'(col_q) == COLS - 1) begin
                        col_d = '0;
                        if (int'(row_q) == ROWS - 1) begin
                            state_d = S_GAP;
                        end else begin
                            row_d   = row_q + ROW_W'(1);
                            state_d = S_ADDR;
                        end
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                end
                S_GAP: begin
                    state_d = S_ADDR;
                    row_d   = '0;
                end
                default: begin
                    state_d = S_WAIT;
                    row_d   = '0;
                    col_d   = '0;
                end
            endcase
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Value presented on DB for the slot being entered. The buffer is read from
    // the registered copy, so a write landing on the same edge is not seen.
    always_comb begin
        rd_idx_s = ADDR_W'(int'(row_d) * COLS + int'(col_d));
        case (state_d)
            S_FUNC:  slot_data_s = FUNC_CMD;
            S_DISP:  slot_data_s = 8'h0C;
            S_ENTRY: slot_data_s = 8'h06;
            S_CLEAR: slot_data_s = 8'h01;
            S_ADDR:  slot_data_s = 8'h80 | row_base(row_d);
            S_CHAR:  slot_data_s = buf_q[rd_idx_s];
            default: slot_data_s = 8'h00;
        endcase
    end

    // Pin outputs are computed from the next state so the flops line up with the slot.
    always_comb begin
        enb_d        = 1'b0;
        rs_d         = rs_q;
        data_d       = data_q;
        frame_done_d = 1'b0;
        ready_d      = ready_q | (state_d == S_ADDR);
        case (state_d)
            S_WAIT: begin
                rs_d   = 1'b0;
                data_d = 8'h00;
            end
            S_GAP: begin
                frame_done_d = (cnt_d == '0);
            end
            default: begin
                enb_d = (cnt_d >= CNT_W'(1)) && (cnt_d <= CNT_W'(EN_W));
                if (cnt_d == '0) begin
                    rs_d   = (state_d == S_CHAR);
                    data_d = slot_data_s;
                end else begin
                    rs_d   = rs_q;
                    data_d = data_q;
                end
            end
        endcase
    end

    // Character buffer update: clear beats write, out-of-range writes are dropped.
    always_comb begin
        buf_d = buf_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_d[i] = 8'h20;
            end
        end else if (wr_en && (int'(wr_addr) < DEPTH)) begin
            buf_d[wr_addr] = wr_data;
        end else begin
            buf_d = buf_q;
        end
    end

    // State, counters, output pins and buffer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_WAIT;
            cnt_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            ready_q      <= 1'b0;
            frame_done_q <= 1'b0;
            enb_q        <= 1'b0;
            rs_q         <= 1'b0;
            data_q       <= 8'h00;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= 8'h20;
            end
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            col_q        <= col_d;
            ready_q      <= ready_d;
            frame_done_q <= frame_done_d;
            enb_q        <= enb_d;
            rs_q         <= rs_d;
            data_q       <= data_d;
            buf_q        <= buf_d;
        end
    end

    assign ready      = ready_q;
    assign frame_done = frame_done_q;
    assign lcd_enb    = enb_q;
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_data   = data_q;

endmodule

// File: tb/tb_text_lcd_ctrl.sv
// Directed bench for text_lcd_ctrl using the small simulation parameter set.
// A refresh frame is 65 cycles: ADDR row0 (6), 4 chars (24), ADDR row1 (6),
// 4 chars (24), gap (5).
module tb_text_lcd_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [7:0] wr_data;
    logic       clr;
    logic       ready;
    logic       frame_done;
    logic       lcd_enb;
    logic       lcd_rs;
    logic       lcd_rw;
    logic [7:0] lcd_data;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [63:0] CH_SPACES = 64'h2020202020202020;
    localparam logic [63:0] CH_WRITE  = 64'h2020212020206948;
    localparam logic [63:0] CH_COLL   = 64'h2020212020416948;

    // per-cycle capture {rw, frame_done, enb, rs, data}
    logic [11:0] cap [65];

    text_lcd_ctrl #(
        .COLS(4), .ROWS(2), .INIT_WAIT(10), .CMD_HOLD(8), .CLEAR_WAIT(12),
        .CHAR_HOLD(6), .REFRESH_GAP(5), .EN_W(2)
    ) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .clr(clr), .ready(ready), .frame_done(frame_done), .lcd_enb(lcd_enb),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected {rw, fd, enb, rs, data} at cycle i of a frame with chars ch (char k at ch[8k+:8]).
    function automatic logic [11:0] exp_vec(input logic [63:0] ch, input int i);
        logic [7:0] d;
        logic       rs;
        logic       en;
        logic       fd;
        if (i < 6) begin
            d = 8'h80; rs = 1'b0;
        end else if (i < 30) begin
            d = ch[8*((i-6)/6) +: 8]; rs = 1'b1;
        end else if (i < 36) begin
            d = 8'hC0; rs = 1'b0;
        end else if (i < 60) begin
            d = ch[8*(4+(i-36)/6) +: 8]; rs = 1'b1;
        end else begin
            d = ch[63:56]; rs = 1'b1;
        end
        en = (i < 60) && ((i % 6 == 1) || (i % 6 == 2));
        fd = (i == 60);
        return {1'b0, fd, en, rs, d};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Record one full frame starting at the current cycle; one-shot inputs are dropped after each edge.
    task automatic capture();
        for (int i = 0; i < 65; i++) begin
            cap[i] = {lcd_rw, frame_done, lcd_enb, lcd_rs, lcd_data};
            step();
            wr_en = 1'b0;
            clr   = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0; wr_addr = 3'd0; wr_data = 8'h00; clr = 1'b0;
        repeat (3) step();
        n_checks++;
        if ({lcd_enb, lcd_rs, lcd_rw, ready, frame_done} !== 5'b0 || lcd_data !== 8'h00) begin
            n_fail++;
            $display("FAIL reset: got enb=%b rs=%b rw=%b ready=%b fd=%b data=%h, want all 0",
                     lcd_enb, lcd_rs, lcd_rw, ready, frame_done, lcd_data);
        end
        rst = 1'b0;
    endtask

    // Called right after rst is released (cycle 0); ends at cycle 46, first ADDR slot.
    task automatic test_init();
        for (int c = 0; c < 46; c++) begin
            logic [7:0] ed;
            logic       ee;
            int         s;
            if (c < 10) begin
                ed = 8'h00; s = 0;
            end else if (c < 18) begin
                ed = 8'h38; s = c - 10;
            end else if (c < 26) begin
                ed = 8'h0C; s = c - 18;
            end else if (c < 34) begin
                ed = 8'h06; s = c - 26;
            end else begin
                ed = 8'h01; s = c - 34;
            end
            ee = (c >= 10) && (s == 1 || s == 2);
            n_checks++;
            if (lcd_data !== ed || lcd_enb !== ee || lcd_rs !== 1'b0 || lcd_rw !== 1'b0
                || ready !== 1'b0 || frame_done !== 1'b0) begin
                n_fail++;
                $display("FAIL init c=%0d: got data=%h enb=%b rs=%b ready=%b fd=%b, want data=%h enb=%b rs=0 ready=0 fd=0",
                         c, lcd_data, lcd_enb, lcd_rs, ready, frame_done, ed, ee);
            end
            step();
        end
        n_checks++;
        if (ready !== 1'b1 || lcd_data !== 8'h80 || lcd_rs !== 1'b0 || lcd_enb !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_rise c=46: got ready=%b data=%h rs=%b enb=%b, want ready=1 data=80 rs=0 enb=0",
                     ready, lcd_data, lcd_rs, lcd_enb);
        end
    endtask

    task automatic test_default_frame();
        for (int f = 0; f < 2; f++) begin
            capture();
            for (int i = 0; i < 65; i++) begin
                n_checks++;
                if (cap[i] !== exp_vec(CH_SPACES, i)) begin
                    n_fail++;
                    $display("FAIL default_frame f=%0d i=%0d: got %h, want %h", f, i, cap[i], exp_vec(CH_SPACES, i));
                end
            end
        end
    endtask

    task automatic test_write_before_ready();
        bit found;
        int cyc;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h48; step();
        wr_addr = 3'd1; wr_data = 8'h69; step();
        wr_addr = 3'd5; wr_data = 8'h21; step();
        wr_en = 1'b0;
        cyc = 3;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            if (ready === 1'b1) found = 1'b1;
            else begin
                step();
                cyc++;
            end
        end
        n_checks++;
        if (!found || cyc != 46) begin
            n_fail++;
            $display("FAIL write_ready_time: got found=%0d cycle=%0d, want found=1 cycle=46", found, cyc);
        end
        capture();
        for (int i = 0; i < 65; i++) begin
            n_checks++;
            if (cap[i] !== exp_vec(CH_WRITE, i)) begin
                n_fail++;
                $display("FAIL write_frame i=%0d: got %h, want %h", i, cap[i], exp_vec(CH_WRITE, i));
            end
        end
    endtask

    // Char slot for index 2 starts at frame cycle 18; the write is sampled on that same edge.
    task automatic test_collision();
        for (int i = 0; i < 65; i++) begin
            if (i == 18) begin
                n_checks++;
                if (lcd_data !== 8'h20 || lcd_rs !== 1'b1) begin
                    n_fail++;
                    $display("FAIL collision_same_frame: got data=%h rs=%b, want data=20 rs=1", lcd_data, lcd_rs);
                end
            end
            if (i == 17) begin
                wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'h41;
            end
            step();
            wr_en = 1'b0;
        end
        capture();
        for (int i = 0; i < 65; i++) begin
            n_checks++;
            if (cap[i] !== exp_vec(CH_COLL, i)) begin
                n_fail++;
                $display("FAIL collision_next_frame i=%0d: got %h, want %h", i, cap[i], exp_vec(CH_COLL, i));
            end
        end
    endtask

    task automatic test_clr_priority();
        clr = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h55;
        capture();
        for (int i = 0; i < 65; i++) begin
            n_checks++;
            if (cap[i] !== exp_vec(CH_SPACES, i)) begin
                n_fail++;
                $display("FAIL clr_frame i=%0d: got %h, want %h", i, cap[i], exp_vec(CH_SPACES, i));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'h4B;
        step();
        wr_en = 1'b0;
        repeat (18) step();
        n_checks++;
        if (lcd_enb !== 1'b1 || lcd_rs !== 1'b1 || ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_char_pre: got enb=%b rs=%b ready=%b, want enb=1 rs=1 ready=1", lcd_enb, lcd_rs, ready);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if (lcd_enb !== 1'b0 || lcd_data !== 8'h00 || ready !== 1'b0 || lcd_rs !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got enb=%b data=%h ready=%b rs=%b fd=%b, want 0 00 0 0 0",
                     lcd_enb, lcd_data, ready, lcd_rs, frame_done);
        end
        #1;
        rst = 1'b0;
        test_init();
        capture();
        for (int i = 0; i < 65; i++) begin
            n_checks++;
            if (cap[i] !== exp_vec(CH_SPACES, i)) begin
                n_fail++;
                $display("FAIL post_reset_frame i=%0d: got %h, want %h", i, cap[i], exp_vec(CH_SPACES, i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_default_frame();
        test_write_before_ready();
        test_collision();
        test_clr_priority();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
